// File: rtl/instr_encoder_if.sv
// Request and output-stream bundle for the instruction encoder.
// master = request producer / word consumer; slave = the encoder itself.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [1:0]  cin_mode;
  logic [1:0]  shift_mode;
  logic [1:0]  rn;
  logic [1:0]  rm;
  logic [1:0]  rx;
  logic [3:0]  amount;
  logic        mem_shift;
  logic [8:0]  imm;
  logic [10:0] addr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;

  modport master (
    output in_valid, op, cin_mode, shift_mode, rn, rm, rx, amount,
           mem_shift, imm, addr, out_ready,
    input  in_ready, out_valid, out_instr
  );

  modport slave (
    input  in_valid, op, cin_mode, shift_mode, rn, rm, rx, amount,
           mem_shift, imm, addr, out_ready,
    output in_ready, out_valid, out_instr
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic ALU instruction requests into 16-bit words, buffers them in
// a small FIFO behind a valid/ready stream, counts handed-off words and keeps
// a sticky flag for illegal opcodes.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_encoder_if.slave bus,
  output logic [CW-1:0]  level,
  output logic [15:0]    issued_cnt,
  output logic           err_illegal,
  input  logic           err_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [3:0] OP_ADR = 4'd0;
  localparam logic [3:0] OP_ADM = 4'd1;
  localparam logic [3:0] OP_ADI = 4'd2;
  localparam logic [3:0] OP_SBR = 4'd3;
  localparam logic [3:0] OP_SBM = 4'd4;
  localparam logic [3:0] OP_SBI = 4'd5;
  localparam logic [3:0] OP_MLR = 4'd6;
  localparam logic [3:0] OP_XSL = 4'd7;
  localparam logic [3:0] OP_XSR = 4'd8;
  localparam logic [3:0] OP_BBO = 4'd9;
  localparam logic [3:0] OP_LDR = 4'd10;
  localparam logic [3:0] OP_STI = 4'd11;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] level_q, level_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [15:0]   word_d;
  logic          legal_d;
  logic          accept, push, pop;

  // Combinational packing of the request fields into an instruction word.
  always_comb begin
    word_d  = '0;
    legal_d = 1'b1;
    case (bus.op)
      OP_ADR: word_d = {5'b00001, 1'b0, bus.cin_mode, bus.shift_mode, bus.rx, bus.rn, bus.rm};
      OP_SBR: word_d = {5'b00101, 1'b0, bus.cin_mode, bus.shift_mode, bus.rx, bus.rn, bus.rm};
      OP_MLR: word_d = {5'b01001, 1'b0, bus.cin_mode, bus.shift_mode, bus.rx, bus.rn, bus.rm};
      OP_ADM: word_d = {5'b00010, bus.addr};
      OP_SBM: word_d = {5'b00110, bus.addr};
      OP_ADI: word_d = {5'b00100, bus.rn, bus.imm};
      OP_SBI: word_d = {5'b01000, bus.rn, bus.imm};
      OP_XSL: word_d = {5'b01010, 1'b0, bus.cin_mode, bus.amount, 2'b00, bus.rm};
      OP_XSR: word_d = {5'b01011, 1'b0, bus.cin_mode, bus.amount, 2'b00, bus.rm};
      OP_BBO: word_d = {5'b01100, 7'b0000000, bus.rn, bus.rm};
      OP_LDR: word_d = {5'b01110, 2'b00, bus.mem_shift, bus.rn, bus.rm, bus.amount};
      OP_STI: word_d = {5'b01111, 2'b00, bus.mem_shift, bus.rn, bus.rm, bus.amount};
      default: legal_d = 1'b0;
    endcase
  end

  // Handshakes: a full FIFO refuses input even if it is popped this cycle,
  // so in_ready never depends on out_ready. Illegal requests are accepted
  // but never written.
  assign bus.in_ready  = (level_q != FULL);
  assign bus.out_valid = (level_q != '0);
  assign accept        = bus.in_valid & bus.in_ready;
  assign push          = accept & legal_d;
  assign pop           = bus.out_valid & bus.out_ready;

  // Head word is masked while empty so nothing stale is visible after reset.
  assign bus.out_instr = bus.out_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign level         = level_q;
  assign issued_cnt    = cnt_q;
  assign err_illegal   = err_q;

  // Next-state for pointers, occupancy, issue counter and sticky error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d    = cnt_q + 16'd1;
    end
    if (push && !pop)      level_d = level_q + CW'(1);
    else if (!push && pop) level_d = level_q - CW'(1);
    // A new illegal accept outranks a same-cycle clear.
    if (accept && !legal_d) err_d = 1'b1;
    else if (err_clr)       err_d = 1'b0;
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage; contents need no reset because the output is masked by level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word_d;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios with literal expectations plus
// a randomized phase, all cross-checked every cycle against a queue model.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] level;
  logic [15:0]   issued_cnt;
  logic          err_illegal;
  logic          err_clr;

  instr_encoder_if bus ();

  instr_encoder #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .level      (level),
    .issued_cnt (issued_cnt),
    .err_illegal(err_illegal),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: opcode table and field weights by plain arithmetic.
  function automatic logic [15:0] model_encode(input int op, input int cin, input int sh,
      input int rn, input int rm, input int rx, input int amt, input int ms,
      input int imm, input int addr);
    int opc [12];
    int w;
    opc = '{1, 2, 4, 5, 6, 8, 9, 10, 11, 12, 14, 15};
    w = opc[op] * 2048;
    case (op)
      0, 3, 6: w = w + cin * 256 + sh * 64 + rx * 16 + rn * 4 + rm;
      1, 4:    w = w + addr;
      2, 5:    w = w + rn * 512 + imm;
      7, 8:    w = w + cin * 256 + amt * 16 + rm;
      9:       w = w + rn * 4 + rm;
      default: w = w + ms * 256 + rn * 64 + rm * 16 + amt;
    endcase
    return 16'(w);
  endfunction

  // Behavioural model state.
  logic [15:0] mq [$];
  logic [15:0] mcnt;
  bit          merr;
  bit          m_acc, m_pop;

  // Model update from the inputs the bench drove for this edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mcnt = 16'h0;
      merr = 1'b0;
    end else begin
      m_acc = bus.in_valid && (mq.size() < DEPTH);
      m_pop = bus.out_ready && (mq.size() > 0);
      if (m_pop) begin
        void'(mq.pop_front());
        mcnt = mcnt + 16'h1;
      end
      if (m_acc && bus.op < 4'd12)
        mq.push_back(model_encode(int'(bus.op), int'(bus.cin_mode), int'(bus.shift_mode),
                                  int'(bus.rn), int'(bus.rm), int'(bus.rx), int'(bus.amount),
                                  int'(bus.mem_shift), int'(bus.imm), int'(bus.addr)));
      if (m_acc && bus.op >= 4'd12) merr = 1'b1;
      else if (err_clr)             merr = 1'b0;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      check("m_out_instr", 32'(bus.out_instr), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      check("m_level", 32'(level), 32'(mq.size()));
      check("m_in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
      check("m_issued", 32'(issued_cnt), 32'(mcnt));
      check("m_err", 32'(err_illegal), 32'(merr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int op, input int cin, input int sh, input int rn, input int rm,
                     input int rx, input int amt, input int ms, input int imm, input int addr);
    bus.in_valid   = 1'b1;
    bus.op         = 4'(op);
    bus.cin_mode   = 2'(cin);
    bus.shift_mode = 2'(sh);
    bus.rn         = 2'(rn);
    bus.rm         = 2'(rm);
    bus.rx         = 2'(rx);
    bus.amount     = 4'(amt);
    bus.mem_shift  = 1'(ms);
    bus.imm        = 9'(imm);
    bus.addr       = 11'(addr);
  endtask

  task automatic rand_req();
    req(int'($urandom_range(0, 11)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
        int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), int'($urandom_range(0, 511)),
        int'($urandom_range(0, 2047)));
  endtask

  task automatic adr_scenario(input string tag);
    bus.out_ready = 1'b1;
    req(0, 1, 2, 2, 3, 1, 0, 0, 0, 0);
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_instr"}, 32'(bus.out_instr), 32'h099B);
    tick();
    check({tag, "_level"}, 32'(level), 32'd0);
  endtask

  logic [15:0] exp_seq [4];
  int guard;

  initial begin
    rst_n = 1'b0;
    err_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    req(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset values.
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_instr", 32'(bus.out_instr), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_cnt", 32'(issued_cnt), 32'd0);
    check("rst_err", 32'(err_illegal), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single ADR.
    adr_scenario("adr1");
    check("adr1_cnt", 32'(issued_cnt), 32'd1);

    // Back-to-back fill with consumer stalled.
    bus.out_ready = 1'b0;
    req(10, 0, 0, 1, 2, 0, 3, 1, 0, 0);    tick();
    req(5, 0, 0, 3, 0, 0, 0, 0, 'h1A5, 0); tick();
    req(8, 3, 0, 0, 2, 0, 5, 0, 0, 0);     tick();
    req(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h7FF); tick();
    check("fill_level", 32'(level), 32'd4);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);
    req(9, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tick(); tick();
    check("stall_level", 32'(level), 32'd4);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    exp_seq = '{16'h7163, 16'h47A5, 16'h5B52, 16'h17FF};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_word%0d", k), 32'(bus.out_instr), 32'(exp_seq[k]));
      tick();
      if (k == 0) check("drain_in_ready", 32'(bus.in_ready), 32'd1);
    end
    check("drain_level", 32'(level), 32'd0);
    check("drain_cnt", 32'(issued_cnt), 32'd5);

    // Full FIFO with simultaneous push attempt and pop.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin rand_req(); tick(); end
    rand_req();
    bus.out_ready = 1'b1;
    tick();
    check("fullpp_level", 32'(level), 32'd3);
    bus.out_ready = 1'b0;
    tick();
    check("fullpp_push", 32'(level), 32'd4);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("fullpp_empty", 32'(level), 32'd0);

    // Illegal opcodes and sticky error.
    req(13, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("ill_level", 32'(level), 32'd0);
    check("ill_err", 32'(err_illegal), 32'd1);
    req(14, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    err_clr = 1'b1;
    tick();
    check("ill_setwins", 32'(err_illegal), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    check("ill_clr", 32'(err_illegal), 32'd0);
    err_clr = 1'b0;

    // Randomized traffic, checked by the every-cycle compare process.
    for (int c = 0; c < 3000; c++) begin
      rand_req();
      if ($urandom_range(0, 7) == 0) bus.op = 4'($urandom_range(12, 15));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      err_clr       = ($urandom_range(0, 15) == 0);
      tick();
    end
    err_clr = 1'b0;

    // Stream until the issue counter reaches 0xFFFF, then wrap it.
    req(2, 0, 0, 1, 0, 0, 0, 0, 7, 0);
    bus.out_ready = 1'b1;
    guard = 0;
    while (mcnt != 16'hFFFF && guard < 70000) begin
      tick();
      guard++;
    end
    check("wrap_reached", 32'(guard < 70000), 32'd1);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    check("wrap_ffff", 32'(issued_cnt), 32'hFFFF);
    tick();
    bus.out_ready = 1'b1;
    tick();
    check("wrap_zero", 32'(issued_cnt), 32'h0000);

    // Asynchronous reset with a partly full FIFO.
    repeat (5) tick();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin rand_req(); tick(); end
    bus.in_valid = 1'b0;
    check("arst_pre_level", 32'(level), 32'd3);
    check("arst_pre_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_instr", 32'(bus.out_instr), 32'd0);
    check("arst_cnt", 32'(issued_cnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    check("arst_after_level", 32'(level), 32'd0);
    adr_scenario("adr2");
    check("adr2_cnt", 32'(issued_cnt), 32'd1);

    bus.out_ready = 1'b0;
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
